abcd_sweep_sequencer: RTL

//  Drives the 4-bit input code {A,B,C,D} into the Y1/Y2 minterm decoder and samples its outputs.

---
 rtl/abcd_sweep_pkg.sv | 18 +
 rtl/abcd_sweep_sequencer_if.sv | 33 +++
 rtl/abcd_dwell_timer.sv | 24 ++
 rtl/abcd_sweep_sequencer.sv | 97 +++++++++
 4 files changed

// File: rtl/abcd_sweep_pkg.sv
// abcd_sweep_pkg: shared types and constants for the ABCD decoder sweep sequencer.
//   CODE_W/MAP_W   code width and truth-table map width
//   state_t        sequencer FSM states IDLE/DRIVE/STEP/DONE
//   Y1_EXPECT      golden Y1 truth table (minterms 4,5,6,7,11,12,13)
//   Y2_EXPECT      golden Y2 truth table (minterms 1,2,4,5)
//   range_mask()   bits lo..hi set, used to limit golden compares to the swept range
package abcd_sweep_pkg;
    localparam int CODE_W = 4;
    localparam int MAP_W = 2 ** CODE_W;
    localparam logic [MAP_W-1:0] Y1_EXPECT = 16'h38F0;
    localparam logic [MAP_W-1:0] Y2_EXPECT = 16'h0036;
    typedef enum logic [1:0] {IDLE, DRIVE, STEP, DONE} state_t;
    function automatic logic [MAP_W-1:0] range_mask(input logic [CODE_W-1:0] lo, input logic [CODE_W-1:0] hi);
        range_mask = '0;
        for (int i = 0; i < MAP_W; i++)
            range_mask[i] = (i >= int'(lo)) && (i <= int'(hi));
    endfunction
endpackage

// File: rtl/abcd_sweep_sequencer_if.sv
// abcd_sweep_sequencer_if: control, status and decoder-loop signals of the sweep sequencer.
//   start/dir/pause/lo/hi   sweep request and bounds (master -> slave)
//   Y1_in/Y2_in             decoder response (master -> slave)
//   A,B,C,D/code_valid      code driven into the decoder (slave -> master)
//   busy/done/err           sweep status (slave -> master)
//   y1_map/y2_map           captured truth tables (slave -> master)
//   mismatch                golden-compare flag, present only with SWEEP_CHECK_EN
interface abcd_sweep_sequencer_if;
    import abcd_sweep_pkg::*;
    logic start, dir, pause;
    logic [CODE_W-1:0] lo, hi;
    logic Y1_in, Y2_in;
    logic A, B, C, D, code_valid;
    logic busy, done, err;
    logic [MAP_W-1:0] y1_map, y2_map;
`ifdef SWEEP_CHECK_EN
    logic mismatch;
`endif
    modport master (
        output start, dir, pause, lo, hi, Y1_in, Y2_in,
        input A, B, C, D, code_valid, busy, done, err, y1_map, y2_map
`ifdef SWEEP_CHECK_EN
        , input mismatch
`endif
    );
    modport slave (
        input start, dir, pause, lo, hi, Y1_in, Y2_in,
        output A, B, C, D, code_valid, busy, done, err, y1_map, y2_map
`ifdef SWEEP_CHECK_EN
        , output mismatch
`endif
    );
endinterface

// File: rtl/abcd_dwell_timer.sv
// abcd_dwell_timer: per-code dwell counter with pause and terminal-count flag.
//   clock, reset   clock and synchronous active-high reset
//   run            counter active (sequencer in DRIVE); held at 0 otherwise
//   pause          freezes the counter
//   tc             last dwell cycle and not paused: capture and leave DRIVE this edge
module abcd_dwell_timer #(
    parameter int DWELL = 5
) (
    input  logic clock,
    input  logic reset,
    input  logic run,
    input  logic pause,
    output logic tc
);
    localparam int W = $clog2(DWELL + 1);
    logic [W-1:0] cnt;
    always_ff @(posedge clock) begin
        if (reset || !run)
            cnt <= '0;
        else if (!pause)
            cnt <= cnt + W'(1);
    end
    assign tc = run && !pause && (cnt == W'(DWELL - 1));
endmodule

// File: rtl/abcd_sweep_sequencer.sv
// abcd_sweep_sequencer: sweeps codes lo..hi into the ABCD decoder and captures Y1/Y2 truth-table maps.
//   clock, reset   clock and synchronous active-high reset
//   bus            abcd_sweep_sequencer_if.slave: request, bounds, decoder loop, status, maps
//   DWELL          cycles each code is held; response sampled on the last one
//   Optional macro SWEEP_CHECK_EN adds bus.mismatch, set at DONE when a swept map bit differs from the golden tables.
module abcd_sweep_sequencer
    import abcd_sweep_pkg::*;
#(
    parameter int DWELL = 5
) (
    input logic clock,
    input logic reset,
    abcd_sweep_sequencer_if.slave bus
);
    state_t state, state_nx;
    logic [CODE_W-1:0] code, lo_r, hi_r;
    logic dir_r, tc, at_end, accept, reject;
    logic [MAP_W-1:0] y1_map, y2_map;

    abcd_dwell_timer #(.DWELL(DWELL)) u_timer (
        .clock (clock),
        .reset (reset),
        .run   (state == DRIVE),
        .pause (bus.pause),
        .tc    (tc)
    );

    always_comb begin
        state_nx = state;
        accept = (state == IDLE) && bus.start && (bus.lo <= bus.hi);
        reject = (state == IDLE) && bus.start && (bus.lo > bus.hi);
        at_end = dir_r ? (code == lo_r) : (code == hi_r);
        unique case (state)
            IDLE:  state_nx = accept ? DRIVE : IDLE;
            DRIVE: state_nx = tc ? STEP : DRIVE;
            STEP:  state_nx = at_end ? DONE : DRIVE;
            DONE:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        state <= reset ? IDLE : state_nx;
    end

    // Status outputs are registered so they change on the edge the FSM leaves a state:
    // done rises on the edge leaving DONE, one cycle after the last STEP.
    always_ff @(posedge clock) begin
        if (reset) begin
            code <= '0;
            lo_r <= '0;
            hi_r <= '0;
            dir_r <= 1'b0;
            y1_map <= '0;
            y2_map <= '0;
            bus.code_valid <= 1'b0;
            bus.busy <= 1'b0;
            bus.done <= 1'b0;
            bus.err <= 1'b0;
        end else begin
            bus.err <= reject;
            bus.done <= (state == DONE);
            if (accept) begin
                lo_r <= bus.lo;
                hi_r <= bus.hi;
                dir_r <= bus.dir;
                code <= bus.dir ? bus.hi : bus.lo;
                y1_map <= '0;
                y2_map <= '0;
                bus.busy <= 1'b1;
                bus.code_valid <= 1'b1;
            end
            if (tc) begin
                y1_map[code] <= bus.Y1_in;
                y2_map[code] <= bus.Y2_in;
            end
            if (state == STEP && !at_end)
                code <= dir_r ? code - CODE_W'(1) : code + CODE_W'(1);
            if (state == DONE) begin
                bus.busy <= 1'b0;
                bus.code_valid <= 1'b0;
            end
        end
    end

`ifdef SWEEP_CHECK_EN
    always_ff @(posedge clock) begin
        if (reset || accept)
            bus.mismatch <= 1'b0;
        else if (state == DONE)
            bus.mismatch <= |(((y1_map ^ Y1_EXPECT) | (y2_map ^ Y2_EXPECT)) & range_mask(lo_r, hi_r));
    end
`endif

    assign {bus.A, bus.B, bus.C, bus.D} = code;
    assign bus.y1_map = y1_map;
    assign bus.y2_map = y2_map;
endmodule
